// File: rtl/vend_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : vend_pkg                                                      |
// | Brief    : State encoding and default constants for vend_dispenser.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

package vend_pkg;

   localparam int c_PULSE_CYC   = 4;
   localparam int c_TIMEOUT_CYC = 16;
   localparam int c_CNT_W       = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_VEND  = 3'd1,
      ST_EJECT = 3'd2,
      ST_GAP   = 3'd3,
      ST_FAULT = 3'd4
   } vend_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vend_if.sv
// +--------------------------------------------------------------------------+
// | Module   : vend_if                                                       |
// | Brief    : Request/actuator bundle between vending_fsm and dispenser.    |
// |            VEND_DISP_STATS_EN adds the completion counters.              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface vend_if
   import vend_pkg::*;
#(
   parameter int CNT_W = c_CNT_W
) ();

   logic             x;
   logic             y;
   logic             prod_sense;
   logic             motor_on;
   logic             coin_eject;
   logic             busy;
   logic             fault;
   logic             drop;
   logic [CNT_W-1:0] prod_pend;
   logic [CNT_W-1:0] coin_pend;
`ifdef VEND_DISP_STATS_EN
   logic [15:0]      vend_ok_cnt;
   logic [15:0]      coin_cnt;
`endif

`ifdef VEND_DISP_STATS_EN
   modport master (
      output x, y, prod_sense,
      input  motor_on, coin_eject, busy, fault, drop, prod_pend, coin_pend,
      input  vend_ok_cnt, coin_cnt
   );
   modport slave (
      input  x, y, prod_sense,
      output motor_on, coin_eject, busy, fault, drop, prod_pend, coin_pend,
      output vend_ok_cnt, coin_cnt
   );
`else
   modport master (
      output x, y, prod_sense,
      input  motor_on, coin_eject, busy, fault, drop, prod_pend, coin_pend
   );
   modport slave (
      input  x, y, prod_sense,
      output motor_on, coin_eject, busy, fault, drop, prod_pend, coin_pend
   );
`endif

endinterface

`default_nettype wire

// File: rtl/vend_req_q.sv
// +--------------------------------------------------------------------------+
// | Module   : vend_req_q                                                    |
// | Brief    : Rising-edge request detector feeding a saturating pending     |
// |            counter with a sticky overflow flag.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module vend_req_q #(
   parameter int CNT_W = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_req,
   input  wire logic             i_deq,
   input  wire logic             i_block,
   output logic      [CNT_W-1:0] o_pend,
   output logic                  o_drop
);

   localparam logic [CNT_W-1:0] c_MAX = '1;

   logic             r_req_q;
   logic [CNT_W-1:0] r_pend;
   logic             r_drop;
   logic             w_inc;

   assign w_inc = i_req & ~r_req_q & ~i_block;

   // The level history loads during reset too, so a held level is not a request.
   always_ff @(posedge clk) begin
      r_req_q <= i_req;
      if (rst) begin
         r_pend <= '0;
         r_drop <= 1'b0;
      end else begin
         case ({w_inc, i_deq})
            2'b10: begin
               if (r_pend == c_MAX) r_drop <= 1'b1;
               else                 r_pend <= r_pend + CNT_W'(1);
            end
            2'b01:   r_pend <= r_pend - CNT_W'(1);
            default: r_pend <= r_pend;
         endcase
      end
   end

   assign o_pend = r_pend;
   assign o_drop = r_drop;

endmodule

`default_nettype wire

// File: rtl/vend_dispenser.sv
// +--------------------------------------------------------------------------+
// | Module   : vend_dispenser                                                |
// | Brief    : Serves queued product/coin requests: motor with drop-sensor   |
// |            timeout, fixed-width coin pulse. Option: VEND_DISP_STATS_EN.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module vend_dispenser
   import vend_pkg::*;
#(
   parameter int PULSE_CYC   = c_PULSE_CYC,
   parameter int TIMEOUT_CYC = c_TIMEOUT_CYC,
   parameter int CNT_W       = c_CNT_W
) (
   input  wire logic clk,
   input  wire logic rst,
   vend_if.slave     bus
);

   localparam int                 c_TMR_W      = $clog2(max2(PULSE_CYC, TIMEOUT_CYC)) + 1;
   localparam logic [c_TMR_W-1:0] c_TO_LAST    = c_TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [c_TMR_W-1:0] c_PULSE_LAST = c_TMR_W'(PULSE_CYC - 1);

   vend_state_t        r_state, w_state_nxt;
   logic [c_TMR_W-1:0] r_tmr, w_tmr_nxt;
   logic               r_motor, r_coin, r_busy, r_fault;
   logic               w_deq_p, w_deq_c, w_block;
   logic [CNT_W-1:0]   w_prod_pend, w_coin_pend;
   logic               w_drop_p, w_drop_c;

   assign w_block = (r_state == ST_FAULT);

   vend_req_q #(.CNT_W(CNT_W)) u_prod_q (
      .clk(clk), .rst(rst), .i_req(bus.x), .i_deq(w_deq_p), .i_block(w_block),
      .o_pend(w_prod_pend), .o_drop(w_drop_p)
   );

   vend_req_q #(.CNT_W(CNT_W)) u_coin_q (
      .clk(clk), .rst(rst), .i_req(bus.y), .i_deq(w_deq_c), .i_block(w_block),
      .o_pend(w_coin_pend), .o_drop(w_drop_c)
   );

   // Timer only runs inside VEND/EJECT and restarts from 0 on entry.
   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = '0;
      w_deq_p     = 1'b0;
      w_deq_c     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_prod_pend != '0) begin
               w_state_nxt = ST_VEND;
               w_deq_p     = 1'b1;
            end else if (w_coin_pend != '0) begin
               w_state_nxt = ST_EJECT;
               w_deq_c     = 1'b1;
            end
         end
         ST_VEND: begin
            w_tmr_nxt = r_tmr + c_TMR_W'(1);
            if (bus.prod_sense)        w_state_nxt = ST_GAP;
            else if (r_tmr == c_TO_LAST) w_state_nxt = ST_FAULT;
         end
         ST_EJECT: begin
            w_tmr_nxt = r_tmr + c_TMR_W'(1);
            if (r_tmr == c_PULSE_LAST) w_state_nxt = ST_GAP;
         end
         ST_GAP:   w_state_nxt = ST_IDLE;
         ST_FAULT: w_state_nxt = ST_FAULT;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Drives are decoded from the next state so they change with the state flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_motor <= 1'b0;
         r_coin  <= 1'b0;
         r_busy  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_motor <= (w_state_nxt == ST_VEND);
         r_coin  <= (w_state_nxt == ST_EJECT);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_fault <= (w_state_nxt == ST_FAULT);
      end
   end

   assign bus.motor_on   = r_motor;
   assign bus.coin_eject = r_coin;
   assign bus.busy       = r_busy;
   assign bus.fault      = r_fault;
   assign bus.drop       = w_drop_p | w_drop_c;
   assign bus.prod_pend  = w_prod_pend;
   assign bus.coin_pend  = w_coin_pend;

`ifdef VEND_DISP_STATS_EN
   logic [15:0] r_vend_ok_cnt, r_coin_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vend_ok_cnt <= '0;
         r_coin_cnt    <= '0;
      end else begin
         if (r_state == ST_VEND && w_state_nxt == ST_GAP)
            r_vend_ok_cnt <= r_vend_ok_cnt + 16'd1;
         if (r_state == ST_EJECT && w_state_nxt == ST_GAP)
            r_coin_cnt <= r_coin_cnt + 16'd1;
      end
   end

   assign bus.vend_ok_cnt = r_vend_ok_cnt;
   assign bus.coin_cnt    = r_coin_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vend_dispenser.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_vend_dispenser                                             |
// | Brief    : Table vectors, directed corner cases and random traffic       |
// |            against an activity/duration reference model.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vend_dispenser;

   localparam int c_PULSE = 4;
   localparam int c_TO    = 16;
   localparam int c_PMAX  = 3;

   localparam int A_IDLE  = 0;
   localparam int A_VEND  = 1;
   localparam int A_EJECT = 2;
   localparam int A_GAP   = 3;
   localparam int A_FAULT = 4;

   typedef struct {
      logic [3:0] in;    // {x, y, prod_sense, rst}
      logic [3:0] out;   // {motor_on, coin_eject, busy, fault}
      logic [1:0] pp;
      logic [1:0] cp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_pass = 0;
   int   n_chk  = 0;
   vec_t tbl[$];

   int   m_act, m_n, m_pp, m_cp, m_vok, m_cc;
   bit   m_drop, m_xl, m_yl;

   vend_if #(.CNT_W(2)) bus ();

   vend_dispenser #(.PULSE_CYC(c_PULSE), .TIMEOUT_CYC(c_TO), .CNT_W(2)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Reference: one activity at a time, each with a duration count.
   task automatic model_step(input logic [3:0] v);
      int  px, py, dp, dc;
      bit  blocked;
      if (v[0]) begin
         m_act = A_IDLE; m_n = 0; m_pp = 0; m_cp = 0;
         m_drop = 0; m_vok = 0; m_cc = 0;
      end else begin
         px = (v[3] && !m_xl) ? 1 : 0;
         py = (v[2] && !m_yl) ? 1 : 0;
         dp = 0; dc = 0;
         blocked = (m_act == A_FAULT);
         case (m_act)
            A_IDLE: begin
               if (m_pp > 0)      begin dp = 1; m_act = A_VEND;  m_n = 1; end
               else if (m_cp > 0) begin dc = 1; m_act = A_EJECT; m_n = 1; end
            end
            A_VEND: begin
               if (v[1])            begin m_act = A_GAP; m_vok++; end
               else if (m_n == c_TO) m_act = A_FAULT;
               else                  m_n++;
            end
            A_EJECT: begin
               if (m_n == c_PULSE) begin m_act = A_GAP; m_cc++; end
               else                m_n++;
            end
            A_GAP:   m_act = A_IDLE;
            default: ;
         endcase
         if (blocked) begin px = 0; py = 0; end
         m_pp = m_pp + px - dp;
         m_cp = m_cp + py - dc;
         if (m_pp > c_PMAX) begin m_pp = c_PMAX; m_drop = 1; end
         if (m_cp > c_PMAX) begin m_cp = c_PMAX; m_drop = 1; end
      end
      m_xl = v[3];
      m_yl = v[1 + 1];
   endtask

   task automatic cyc(input logic [3:0] v);
      logic [8:0] got, exp;
      bus.x = v[3]; bus.y = v[2]; bus.prod_sense = v[1]; rst = v[0];
      @(posedge clk);
      model_step(v);
      #1;
      got = {bus.drop, bus.prod_pend, bus.coin_pend, bus.fault, bus.busy,
             bus.coin_eject, bus.motor_on};
      exp = {m_drop, 2'(m_pp), 2'(m_cp), m_act == A_FAULT, m_act != A_IDLE,
             m_act == A_EJECT, m_act == A_VEND};
      chk("model", 32'(got), 32'(exp));
`ifdef VEND_DISP_STATS_EN
      chk("model_stats", {bus.vend_ok_cnt, bus.coin_cnt}, {16'(m_vok), 16'(m_cc)});
`endif
   endtask

   task automatic add(input logic [3:0] in, input logic [3:0] out,
                      input logic [1:0] pp, input logic [1:0] cp);
      vec_t t;
      t.in = in; t.out = out; t.pp = pp; t.cp = cp;
      tbl.push_back(t);
   endtask

   initial begin
      int cnt;
      logic xl, yl;
      bus.x = 1'b0; bus.y = 1'b0; bus.prod_sense = 1'b0; rst = 1'b1;
      #1;

      // Single vend, sensor on 3rd motor cycle; then x+y held 5 cycles.
      add(4'b1000, 4'b0000, 2'd1, 2'd0);
      add(4'b0000, 4'b1010, 2'd0, 2'd0);
      add(4'b0000, 4'b1010, 2'd0, 2'd0);
      add(4'b0000, 4'b1010, 2'd0, 2'd0);
      add(4'b0010, 4'b0010, 2'd0, 2'd0);
      add(4'b0000, 4'b0000, 2'd0, 2'd0);
      add(4'b1100, 4'b0000, 2'd1, 2'd1);
      for (int i = 0; i < 4; i++) add(4'b1100, 4'b1010, 2'd0, 2'd1);
      add(4'b0010, 4'b0010, 2'd0, 2'd1);
      add(4'b0000, 4'b0000, 2'd0, 2'd1);
      for (int i = 0; i < 4; i++) add(4'b0000, 4'b0110, 2'd0, 2'd0);
      add(4'b0000, 4'b0010, 2'd0, 2'd0);
      add(4'b0000, 4'b0000, 2'd0, 2'd0);

      cyc(4'b0001);
      cyc(4'b0001);
      chk("reset", 32'({bus.motor_on, bus.coin_eject, bus.busy, bus.fault, bus.drop,
                        bus.prod_pend, bus.coin_pend}), 32'd0);
      foreach (tbl[i]) begin
         cyc(tbl[i].in);
         chk($sformatf("vec%0d", i),
             32'({bus.motor_on, bus.coin_eject, bus.busy, bus.fault, bus.prod_pend, bus.coin_pend}),
             32'({tbl[i].out, tbl[i].pp, tbl[i].cp}));
      end

      // Saturation while the motor is stalled, then an edge on a dequeue edge.
      cyc(4'b0001);
      cyc(4'b1000);
      cyc(4'b0000);
      for (int i = 0; i < 4; i++) begin cyc(4'b1000); cyc(4'b0000); end
      chk("sat_pend", 32'(bus.prod_pend), 32'd3);
      chk("sat_drop", 32'(bus.drop), 32'd1);
      cyc(4'b0010);
      cyc(4'b0000);
      cyc(4'b1000);
      chk("sat_deq_pend", 32'(bus.prod_pend), 32'd3);
      chk("sat_deq_motor", 32'(bus.motor_on), 32'd1);

      // Timeout into FAULT; requests ignored until reset.
      cyc(4'b0001);
      cyc(4'b0001);
      cyc(4'b1000);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(4'b0000);
         if (bus.motor_on) cnt++;
         if (bus.fault) break;
      end
      chk("to_motor_cycles", cnt, 16);
      chk("to_fault", 32'({bus.fault, bus.motor_on, bus.busy}), 32'b101);
      cyc(4'b1000); cyc(4'b0000); cyc(4'b1000);
      chk("fault_ignores_req", 32'({bus.prod_pend, bus.drop, bus.fault}), 32'b001);
      cyc(4'b0001);
      chk("rst_clears_fault", 32'({bus.fault, bus.busy}), 32'd0);

      // Reset during the 2nd eject cycle with x held high.
      cyc(4'b0100);
      cyc(4'b0000);
      chk("eject_start", 32'(bus.coin_eject), 32'd1);
      cyc(4'b1000);
      cyc(4'b1001);
      chk("abort_eject", 32'({bus.coin_eject, bus.busy, bus.prod_pend, bus.coin_pend}), 32'd0);
      for (int i = 0; i < 3; i++) cyc(4'b1000);
      chk("held_x_no_req", 32'({bus.prod_pend, bus.busy, bus.motor_on}), 32'd0);

      // Two vends and one coin for the completion counters.
      cyc(4'b0001);
      cyc(4'b1110);
      cyc(4'b0010);
      cyc(4'b1010);
      for (int i = 0; i < 14; i++) cyc(4'b0010);
      chk("stats_idle", 32'({bus.busy, bus.prod_pend, bus.coin_pend}), 32'd0);
`ifdef VEND_DISP_STATS_EN
      chk("vend_ok_cnt", 32'(bus.vend_ok_cnt), 32'd2);
      chk("coin_cnt", 32'(bus.coin_cnt), 32'd1);
`endif

      // Random traffic checked against the model every cycle.
      xl = 1'b0; yl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(3) == 0) xl = ~xl;
         if ($urandom_range(4) == 0) yl = ~yl;
         cyc({xl, yl, ($urandom_range(4) == 0), ($urandom_range(149) == 0)});
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Actuator-side responder for the vending controller's outputs. It consumes the "product delivered" request (x) and the "coin returned" request (y) and drives the physical product motor and the coin ejector.
- Each x or y rising edge is one request. Requests are queued in saturating pending counters and served one at a time.
- Product vends use a sensor handshake with a timeout. Coin ejects use a fixed-width pulse.
- Sits directly downstream of vending_fsm, in the same clock domain.

Parameters:
- PULSE_CYC, 4, coin_eject high time in cycles (must be >= 1)
- TIMEOUT_CYC, 16, max cycles motor_on may stay high without prod_sense (must be >= 2)
- CNT_W, 2, width of each pending counter; saturates at 2^CNT_W-1

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- x  in  1  product-deliver request from vending_fsm; rising edge = 1 request
- y  in  1  coin-return request from vending_fsm; rising edge = 1 request
- prod_sense  in  1  drop sensor, high when product has fallen
- motor_on  out  1  product motor drive
- coin_eject  out  1  coin ejector solenoid drive
- busy  out  1  high whenever FSM is not IDLE
- fault  out  1  sticky vend-timeout indication
- drop  out  1  sticky: a request arrived while its counter was saturated
- prod_pend  out  CNT_W  queued product requests
- coin_pend  out  CNT_W  queued coin requests

Behaviour:
- Reset (sampled at clk edge while rst=1):
  - All outputs go to 0 and the FSM goes to IDLE.
  - x_q/y_q load the current x/y, so a level held through reset is not a request.
  - Reset mid-VEND or mid-EJECT aborts immediately; the next cycle has motor_on=0 and coin_eject=0.
- Edge detect:
  - px = x & ~x_q, py = y & ~y_q; x_q <= x and y_q <= y every cycle.
  - x held high for N cycles = exactly 1 request.
- Pending counters:
  - Increment on px/py at the sampling edge.
  - Decrement when the FSM dequeues from that counter.
  - Increment and decrement on the same edge: net unchanged.
  - Increment at saturation without a decrement: value held, drop <= 1.
  - In FAULT, increments are ignored and drop is not set.
- FSM states (all outputs registered; Moore):
  - IDLE:
    - if prod_pend > 0: go to VEND, prod_pend -= 1, timer = 0
    - else if coin_pend > 0: go to EJECT, coin_pend -= 1, timer = 0
    - Product has priority over coin.
  - VEND: motor_on = 1; timer increments each cycle.
    - prod_sense=1 sampled: go to GAP.
    - else timer == TIMEOUT_CYC-1: go to FAULT.
    - prod_sense wins if both occur on the same edge.
  - EJECT: coin_eject = 1 for exactly PULSE_CYC consecutive cycles, then go to GAP.
  - GAP: one cycle with all drives low, then go to IDLE. Guarantees motor and solenoid are never both high and never back-to-back.
  - FAULT: all drives low, fault = 1, busy = 1; exited only by rst.
- Latency:
  - x rise sampled at edge k → prod_pend = 1 after k.
  - Edge k+1 → VEND, motor_on = 1, prod_pend = 0.
  - Minimum service time for 1 product + 1 coin: 1 + VEND cycles + 1 GAP + 1 IDLE + PULSE_CYC + 1 GAP.
- Timer width: clog2(max(PULSE_CYC, TIMEOUT_CYC)) + 1. No wrap is possible.

Optional Feature:
- Macro: VEND_DISP_STATS_EN
- Defined:
  - Adds outputs vend_ok_cnt[15:0] (increments on each VEND→GAP) and coin_cnt[15:0] (increments on each EJECT→GAP).
  - Both wrap modulo 2^16 and clear on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package vend_pkg:
  - state encoding: IDLE, VEND, EJECT, GAP, FAULT (3 bits)
  - default constants for PULSE_CYC, TIMEOUT_CYC, CNT_W
- Sub-module vend_req_q:
  - edge detector plus saturating up/down counter plus drop flag
  - instantiated twice (product, coin)

Test Plan:
- Pulse x for 1 cycle, prod_sense=1 on the 3rd VEND cycle → motor_on high exactly 3 cycles, then 1 GAP cycle, busy back to 0; fault=0, prod_pend ends at 0.
- Hold x and y high together for 5 cycles → prod_pend=1 and coin_pend=1; VEND is served first, then EJECT with coin_eject high exactly 4 cycles; no cycle has both drives high.
- 4 x edges while VEND is stalled (CNT_W=2) → prod_pend saturates at 3 and drop=1. A 5th edge coinciding with a dequeue keeps prod_pend at 3.
- prod_sense held 0 → motor_on high exactly 16 cycles, then fault=1 and motor_on=0; later x edges do not change prod_pend; rst clears fault.
- Assert rst on the 2nd EJECT cycle with x held high → next cycle coin_eject=0, counters 0, IDLE; x still high after release produces no request.
- With VEND_DISP_STATS_EN: 2 vends + 1 coin → vend_ok_cnt=2, coin_cnt=1. Without the macro, build and the first five scenarios pass unchanged.
